// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master IO bus arbiter.
package io_arb_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 16;

    localparam logic [15:0] DEAD_VALUE = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    // Returns {wr, rd}; a simultaneous read and write request is serviced as a write.
    function automatic logic [1:0] resolve_op(input logic rd, input logic wr);
        return {wr, rd & ~wr};
    endfunction

endpackage

// File: rtl/io_arb_rr.sv
// Combinational two-way round-robin picker; the last-grant state is kept by the caller.
module io_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the master that was not granted last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter onto a single ready-handshaked peripheral bus.
// Optional ACCESS timeout is enabled by defining IO_BUS_ARBITER_TIMEOUT_EN.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int TIMEOUT = 255
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          m0_rd,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_rd,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic [DW-1:0] m_rdata,
    output logic          s_rd,
    output logic          s_wr,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic          busy,
    output logic          timeout_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    logic [1:0]    req_s;
    logic [1:0]    grant_s;
    logic [1:0]    op_s;
    logic          sel_rd_s;
    logic          sel_wr_s;
    logic          start_s;
    logic          finish_s;
    logic          to_hit_s;
    logic          last_r;
    logic          gnt_r;
    logic          wr_op_r;
    logic          s_rd_r;
    logic          s_wr_r;
    logic          m0_ack_r;
    logic          m1_ack_r;
    logic          busy_r;
    logic          to_err_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] rdata_r;

    assign req_s = {m1_rd | m1_wr, m0_rd | m0_wr};

    io_arb_rr u_rr (
        .req   (req_s),
        .last  (last_r),
        .grant (grant_s)
    );

    assign sel_rd_s = grant_s[1] ? m1_rd : m0_rd;
    assign sel_wr_s = grant_s[1] ? m1_wr : m0_wr;
    assign op_s     = resolve_op(sel_rd_s, sel_wr_s);

`ifdef IO_BUS_ARBITER_TIMEOUT_EN
    logic [7:0] cnt_r;

    // ACCESS wait counter, restarted at every grant.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            cnt_r <= 8'd0;
        end else if (start_s) begin
            cnt_r <= 8'd0;
        end else if ((state_r == ST_ACCESS) && !s_ready) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    // The limit is only consumed by the timeout build.
    logic [7:0] unused_timeout_s;
    assign unused_timeout_s = TO_LAST;
`endif

    // State register.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus single-cycle start/finish events for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        finish_s    = 1'b0;
        to_hit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|grant_s) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (s_ready) begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end
`ifdef IO_BUS_ARBITER_TIMEOUT_EN
                else if (cnt_r == TO_LAST) begin
                    finish_s    = 1'b1;
                    to_hit_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end
`endif
                else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Transfer registers: latched at grant, strobes dropped and ack raised on completion.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            last_r   <= 1'b1;
            gnt_r    <= 1'b0;
            wr_op_r  <= 1'b0;
            s_rd_r   <= 1'b0;
            s_wr_r   <= 1'b0;
            m0_ack_r <= 1'b0;
            m1_ack_r <= 1'b0;
            busy_r   <= 1'b0;
            to_err_r <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
        end else if (start_s) begin
            last_r   <= grant_s[1];
            gnt_r    <= grant_s[1];
            wr_op_r  <= op_s[1];
            s_wr_r   <= op_s[1];
            s_rd_r   <= op_s[0];
            busy_r   <= 1'b1;
            addr_r   <= grant_s[1] ? m1_addr : m0_addr;
            wdata_r  <= grant_s[1] ? m1_wdata : m0_wdata;
        end else if (finish_s) begin
            s_rd_r   <= 1'b0;
            s_wr_r   <= 1'b0;
            m0_ack_r <= ~gnt_r;
            m1_ack_r <= gnt_r;
            to_err_r <= to_hit_s;
            if (!wr_op_r) begin
                rdata_r <= to_hit_s ? DW'(DEAD_VALUE) : s_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end else if (state_r == ST_DONE) begin
            m0_ack_r <= 1'b0;
            m1_ack_r <= 1'b0;
            to_err_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            busy_r   <= busy_r;
        end
    end

    assign m0_ack      = m0_ack_r;
    assign m1_ack      = m1_ack_r;
    assign m_rdata     = rdata_r;
    assign s_rd        = s_rd_r;
    assign s_wr        = s_wr_r;
    assign s_addr      = addr_r;
    assign s_wdata     = wdata_r;
    assign busy        = busy_r;
    assign timeout_err = to_err_r;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter (TIMEOUT=4; honours IO_BUS_ARBITER_TIMEOUT_EN).
module tb_io_bus_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_rd, m0_wr, m1_rd, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m_rdata;
    logic          s_rd, s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;
    logic          s_ready;
    logic          busy, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(4)) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst_n),
        .m0_rd       (m0_rd),
        .m0_wr       (m0_wr),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m1_rd       (m1_rd),
        .m1_wr       (m1_wr),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m0_ack      (m0_ack),
        .m1_ack      (m1_ack),
        .m_rdata     (m_rdata),
        .s_rd        (s_rd),
        .s_wr        (s_wr),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .s_ready     (s_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_rd = 1'b0; m0_wr = 1'b0; m0_addr = 16'h0000; m0_wdata = 16'h0000;
        m1_rd = 1'b0; m1_wr = 1'b0; m1_addr = 16'h0000; m1_wdata = 16'h0000;
        s_rdata = 16'h0000; s_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        m0_rd = 1'b1;
        repeat (2) sample();
        n_checks++;
        if ({s_rd, s_wr, m0_ack, m1_ack, busy, timeout_err} !== 6'b000000) begin
            $display("FAIL reset_ctrl: got %b expected 000000", {s_rd, s_wr, m0_ack, m1_ack, busy, timeout_err});
            n_fail++;
        end
        n_checks++;
        if ({s_addr, s_wdata, m_rdata} !== 48'h0) begin
            $display("FAIL reset_data: got %h expected 0", {s_addr, s_wdata, m_rdata});
            n_fail++;
        end
        step();
        m0_rd = 1'b0;
        rst_n = 1'b1;
        sample();
    endtask

    task automatic test_read();
        step(); m0_rd = 1'b1; m0_addr = 16'h0010; sample();
        n_checks++;
        if ({s_rd, busy} !== 2'b00) begin
            $display("FAIL read_idle: got %b expected 00", {s_rd, busy}); n_fail++;
        end
        step(); s_ready = 1'b1; s_rdata = 16'h1234; sample();
        n_checks++;
        if ({s_rd, s_wr, busy, m0_ack} !== 4'b1010 || s_addr !== 16'h0010) begin
            $display("FAIL read_access: got ctl=%b addr=%h expected ctl=1010 addr=0010", {s_rd, s_wr, busy, m0_ack}, s_addr); n_fail++;
        end
        step(); s_ready = 1'b0; s_rdata = 16'h0000; m0_rd = 1'b0; sample();
        n_checks++;
        if ({m0_ack, m1_ack, s_rd, busy} !== 4'b1001 || m_rdata !== 16'h1234) begin
            $display("FAIL read_ack: got ctl=%b rdata=%h expected ctl=1001 rdata=1234", {m0_ack, m1_ack, s_rd, busy}, m_rdata); n_fail++;
        end
        step(); sample();
        n_checks++;
        if ({m0_ack, busy} !== 2'b00 || m_rdata !== 16'h1234) begin
            $display("FAIL read_after: got ctl=%b rdata=%h expected ctl=00 rdata=1234", {m0_ack, busy}, m_rdata); n_fail++;
        end
    endtask

    task automatic test_slow_write();
        int hi;
        hi = 0;
        step(); m1_rd = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0100; m1_wdata = 16'hBEEF;
        s_ready = 1'b0; s_rdata = 16'h5A5A; sample();
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 2) begin m1_addr = 16'hFFFF; m1_wdata = 16'h0000; end
            s_ready = (i == 5);
            sample();
            if (s_wr === 1'b1) hi++;
            n_checks++;
            if ({s_rd, m0_ack, m1_ack} !== 3'b000 || s_addr !== 16'h0100 || s_wdata !== 16'hBEEF) begin
                $display("FAIL slow_write_cycle%0d: got ctl=%b addr=%h data=%h expected ctl=000 addr=0100 data=beef",
                         i, {s_rd, m0_ack, m1_ack}, s_addr, s_wdata); n_fail++;
            end
        end
        step(); s_ready = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0; sample();
        n_checks++;
        if ({m1_ack, m0_ack, s_wr} !== 3'b100 || m_rdata !== 16'h1234) begin
            $display("FAIL slow_write_ack: got ctl=%b rdata=%h expected ctl=100 rdata=1234", {m1_ack, m0_ack, s_wr}, m_rdata); n_fail++;
        end
        n_checks++;
        if (hi !== 6) begin
            $display("FAIL slow_write_len: got %0d expected 6", hi); n_fail++;
        end
        step(); sample();
    endtask

    task automatic test_contention();
        logic exp_m1;
        apply_reset();
        step();
        m0_wr = 1'b1; m0_addr = 16'h00A0; m0_wdata = 16'hAAAA;
        m1_wr = 1'b1; m1_addr = 16'h0200; m1_wdata = 16'h5555;
        s_ready = 1'b1;
        sample();
        for (int k = 0; k < 4; k++) begin
            exp_m1 = (k % 2 == 1);
            step(); sample();
            n_checks++;
            if (s_wr !== 1'b1 || s_rd !== 1'b0 || s_wdata !== (exp_m1 ? 16'h5555 : 16'hAAAA) ||
                s_addr !== (exp_m1 ? 16'h0200 : 16'h00A0)) begin
                $display("FAIL contention_grant%0d: got wr=%b addr=%h data=%h expected master %0d",
                         k, s_wr, s_addr, s_wdata, exp_m1); n_fail++;
            end
            step(); sample();
            n_checks++;
            if ({m1_ack, m0_ack} !== {exp_m1, ~exp_m1}) begin
                $display("FAIL contention_ack%0d: got m1/m0=%b expected %b", k, {m1_ack, m0_ack}, {exp_m1, ~exp_m1}); n_fail++;
            end
            step();
            if (k == 3) begin m0_wr = 1'b0; m1_wr = 1'b0; s_ready = 1'b0; end
            sample();
        end
        step(); sample();
        n_checks++;
        if (busy !== 1'b0 || m_rdata !== 16'h0000) begin
            $display("FAIL contention_end: got busy=%b rdata=%h expected busy=0 rdata=0000", busy, m_rdata); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        step(); m0_rd = 1'b1; m0_addr = 16'h0030; s_ready = 1'b1; s_rdata = 16'h1111; sample();
        step(); sample();
        n_checks++;
        if (s_rd !== 1'b1 || s_addr !== 16'h0030) begin
            $display("FAIL b2b_access1: got rd=%b addr=%h expected rd=1 addr=0030", s_rd, s_addr); n_fail++;
        end
        step(); s_rdata = 16'h2222; sample();
        n_checks++;
        if (m0_ack !== 1'b1 || m_rdata !== 16'h1111) begin
            $display("FAIL b2b_ack1: got ack=%b rdata=%h expected ack=1 rdata=1111", m0_ack, m_rdata); n_fail++;
        end
        step(); sample();
        n_checks++;
        if ({s_rd, m0_ack, busy} !== 3'b000) begin
            $display("FAIL b2b_idle: got %b expected 000", {s_rd, m0_ack, busy}); n_fail++;
        end
        step(); sample();
        n_checks++;
        if ({s_rd, busy} !== 2'b11) begin
            $display("FAIL b2b_regrant: got %b expected 11", {s_rd, busy}); n_fail++;
        end
        step(); m0_rd = 1'b0; s_ready = 1'b0; sample();
        n_checks++;
        if (m0_ack !== 1'b1 || m_rdata !== 16'h2222) begin
            $display("FAIL b2b_ack2: got ack=%b rdata=%h expected ack=1 rdata=2222", m0_ack, m_rdata); n_fail++;
        end
        step(); sample();
    endtask

    task automatic test_timeout();
        step(); m0_rd = 1'b1; m0_addr = 16'h0040; s_ready = 1'b0; s_rdata = 16'h7777; sample();
`ifdef IO_BUS_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step(); sample();
            n_checks++;
            if ({s_rd, m0_ack, timeout_err} !== 3'b100) begin
                $display("FAIL timeout_wait%0d: got %b expected 100", i, {s_rd, m0_ack, timeout_err}); n_fail++;
            end
        end
        step(); m0_rd = 1'b0; sample();
        n_checks++;
        if ({m0_ack, timeout_err, s_rd} !== 3'b110 || m_rdata !== 16'hDEAD) begin
            $display("FAIL timeout_ack: got ctl=%b rdata=%h expected ctl=110 rdata=dead", {m0_ack, timeout_err, s_rd}, m_rdata); n_fail++;
        end
        step(); sample();
        n_checks++;
        if ({m0_ack, timeout_err, busy} !== 3'b000) begin
            $display("FAIL timeout_after: got %b expected 000", {m0_ack, timeout_err, busy}); n_fail++;
        end
`else
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step(); sample();
                if (m0_ack === 1'b1 || timeout_err === 1'b1) seen = 1'b1;
            end
            n_checks++;
            if (seen !== 1'b0 || {busy, s_rd} !== 2'b11) begin
                $display("FAIL no_timeout: got ack_seen=%b busy/rd=%b expected ack_seen=0 busy/rd=11", seen, {busy, s_rd}); n_fail++;
            end
            apply_reset();
            sample();
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        seen = 1'b0;
        step(); m0_wr = 1'b1; m0_addr = 16'h0050; m0_wdata = 16'h0C0C; s_ready = 1'b0; sample();
        step(); sample();
        n_checks++;
        if ({s_wr, busy} !== 2'b11) begin
            $display("FAIL rst_mid_pre: got %b expected 11", {s_wr, busy}); n_fail++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_wr, s_rd, busy} !== 3'b000 || s_addr !== 16'h0000) begin
            $display("FAIL rst_mid_async: got ctl=%b addr=%h expected ctl=000 addr=0000", {s_wr, s_rd, busy}, s_addr); n_fail++;
        end
        m0_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin step(); rst_n = 1'b1; end
            sample();
            if (m0_ack === 1'b1 || m1_ack === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            $display("FAIL rst_mid_noack: got ack_seen=%b expected 0", seen); n_fail++;
        end
        step(); m0_rd = 1'b1; m0_addr = 16'h0060; m1_rd = 1'b1; m1_addr = 16'h0070;
        s_ready = 1'b1; s_rdata = 16'h4321; sample();
        step(); sample();
        n_checks++;
        if (s_rd !== 1'b1 || s_addr !== 16'h0060) begin
            $display("FAIL rst_tie_grant: got rd=%b addr=%h expected rd=1 addr=0060", s_rd, s_addr); n_fail++;
        end
        step(); m0_rd = 1'b0; s_ready = 1'b0; sample();
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b10 || m_rdata !== 16'h4321) begin
            $display("FAIL rst_tie_ack: got acks=%b rdata=%h expected acks=10 rdata=4321", {m0_ack, m1_ack}, m_rdata); n_fail++;
        end
        step(); m1_rd = 1'b0; sample();
        step(); sample();
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL rst_tie_end: got busy=%b expected 0", busy); n_fail++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_read();
        test_slow_write();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
